// File: rtl/sync_gray_ptr_rd_if.sv
// Bundle of the write-pointer synchroniser signals between the write-pointer source and read-side logic.
// Latency: none (wiring only).
// Backpressure: none; the pointer is sampled every read clock.
interface sync_gray_ptr_rd_if #(
  parameter int FIFO_ADDR_WIDTH = 8
);
  localparam int PW = FIFO_ADDR_WIDTH + 1;

  logic [PW-1:0] wrptr;
  logic          err_clr;
  logic [PW-1:0] rdq_wrptr_gray;
  logic [PW-1:0] rdq_wrptr_bin;
  logic          wrptr_upd;
  logic [PW-1:0] wrptr_delta;
  logic          gray_err;
  logic [7:0]    err_cnt;

  // Write side / stimulus: drives the pointer and the error clear.
  modport master (
    output wrptr,
    output err_clr,
    input  rdq_wrptr_gray,
    input  rdq_wrptr_bin,
    input  wrptr_upd,
    input  wrptr_delta,
    input  gray_err,
    input  err_cnt
  );

  // Synchroniser side.
  modport slave (
    input  wrptr,
    input  err_clr,
    output rdq_wrptr_gray,
    output rdq_wrptr_bin,
    output wrptr_upd,
    output wrptr_delta,
    output gray_err,
    output err_cnt
  );
endinterface

// File: rtl/sync_gray_ptr_rd.sv
// Synchronises a Gray write pointer into rdclk, decodes it to binary, reports per-update advance and sanity errors.
// Latency: SYNC_STAGES edges to rdq_wrptr_gray, SYNC_STAGES+1 edges to binary/update/error outputs.
// Backpressure: none; a new pointer sample is accepted on every rdclk edge.
module sync_gray_ptr_rd #(
  parameter int FIFO_ADDR_WIDTH = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int CHECK_EN        = 1
) (
  input  logic                 rdclk,
  input  logic                 reset_n,
  sync_gray_ptr_rd_if.slave    bus
);
  localparam int PW = FIFO_ADDR_WIDTH + 1;
  // Largest advance a legal writer can show relative to a reader-visible pointer.
  localparam logic [PW-1:0] DEPTH = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("sync_gray_ptr_rd: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0] r_bin;
  logic          r_upd;
  logic [PW-1:0] r_delta;
  logic          r_err;
  logic [7:0]    r_cnt;

  logic [PW-1:0] w_bin_nxt;
  logic [PW-1:0] w_delta;
  logic          w_err_evt;

  // Plain flop chain: no logic between stages so each stage has a full cycle to resolve.
  always_ff @(posedge rdclk) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= bus.wrptr;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // Decode of the last stage; the subtraction wraps naturally at 2^PW.
  always_comb begin
    w_bin_nxt = gray2bin(r_sync[SYNC_STAGES-1]);
    w_delta   = w_bin_nxt - r_bin;
    w_err_evt = (CHECK_EN != 0) && (w_delta > DEPTH);
  end

  // Registered binary pointer with update pulse and advance count.
  always_ff @(posedge rdclk) begin
    if (!reset_n) begin
      r_bin   <= '0;
      r_upd   <= 1'b0;
      r_delta <= '0;
    end else begin
      r_bin   <= w_bin_nxt;
      r_upd   <= (w_delta != '0);
      r_delta <= w_delta;
    end
  end

  // Sanity monitor: an error event takes priority over a simultaneous clear.
  always_ff @(posedge rdclk) begin
    if (!reset_n) begin
      r_err <= 1'b0;
      r_cnt <= 8'd0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
      if (bus.err_clr) begin
        r_cnt <= 8'd1;
      end else if (r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end else if (bus.err_clr) begin
      r_err <= 1'b0;
      r_cnt <= 8'd0;
    end
  end

  assign bus.rdq_wrptr_gray = r_sync[SYNC_STAGES-1];
  assign bus.rdq_wrptr_bin  = r_bin;
  assign bus.wrptr_upd      = r_upd;
  assign bus.wrptr_delta    = r_delta;
  assign bus.gray_err       = r_err;
  assign bus.err_cnt        = r_cnt;
endmodule

// File: tb/tb_sync_gray_ptr_rd.sv
// Directed bench for sync_gray_ptr_rd: three instances (N=2 checked, N=3 checked, N=2 unchecked)
// share one stimulus; expected updates are queued at issue and popped by per-instance monitors.
module tb_sync_gray_ptr_rd;
  logic       rdclk = 1'b0;
  logic       reset_n = 1'b0;
  logic [8:0] wrptr = 9'd0;
  logic       err_clr = 1'b0;

  always #5 rdclk = ~rdclk;

  sync_gray_ptr_rd_if #(.FIFO_ADDR_WIDTH(8)) if2 ();
  sync_gray_ptr_rd_if #(.FIFO_ADDR_WIDTH(8)) if3 ();
  sync_gray_ptr_rd_if #(.FIFO_ADDR_WIDTH(8)) if0 ();

  assign if2.wrptr = wrptr;
  assign if3.wrptr = wrptr;
  assign if0.wrptr = wrptr;
  assign if2.err_clr = err_clr;
  assign if3.err_clr = err_clr;
  assign if0.err_clr = err_clr;

  sync_gray_ptr_rd #(.FIFO_ADDR_WIDTH(8), .SYNC_STAGES(2), .CHECK_EN(1)) dut2 (
    .rdclk(rdclk), .reset_n(reset_n), .bus(if2));
  sync_gray_ptr_rd #(.FIFO_ADDR_WIDTH(8), .SYNC_STAGES(3), .CHECK_EN(1)) dut3 (
    .rdclk(rdclk), .reset_n(reset_n), .bus(if3));
  sync_gray_ptr_rd #(.FIFO_ADDR_WIDTH(8), .SYNC_STAGES(2), .CHECK_EN(0)) dut0 (
    .rdclk(rdclk), .reset_n(reset_n), .bus(if0));

  typedef struct {
    int bin;
    int delta;
    int err;
    int cnt;
    int due;
  } exp_t;

  exp_t q [3][$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   cur = 0;

  always @(posedge rdclk) cyc <= cyc + 1;

  function automatic logic [8:0] g(input int b);
    logic [8:0] v;
    v = b[8:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int id, input string tag, input logic upd, input logic [8:0] bin,
                     input logic [8:0] delta, input logic err, input logic [7:0] cnt);
    exp_t e;
    if (upd) begin
      if (q[id].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s.spurious_upd actual=1 expected=0 (cycle %0d)", tag, cyc);
      end else begin
        e = q[id].pop_front();
        chk({tag, ".bin"}, int'(bin), e.bin);
        chk({tag, ".delta"}, int'(delta), e.delta);
        chk({tag, ".gray_err"}, int'(err), e.err);
        chk({tag, ".err_cnt"}, int'(cnt), e.cnt);
        chk({tag, ".latency_cycle"}, cyc, e.due);
      end
    end else begin
      chk({tag, ".idle_delta"}, int'(delta), 0);
    end
  endtask

  always @(negedge rdclk) begin
    mon(0, "n2", if2.wrptr_upd, if2.rdq_wrptr_bin, if2.wrptr_delta, if2.gray_err, if2.err_cnt);
    mon(1, "n3", if3.wrptr_upd, if3.rdq_wrptr_bin, if3.wrptr_delta, if3.gray_err, if3.err_cnt);
    mon(2, "nochk", if0.wrptr_upd, if0.rdq_wrptr_bin, if0.wrptr_delta, if0.gray_err, if0.err_cnt);
  end

  // Queue the expected update for all instances; called at the negedge the input changes.
  task automatic push(input int b, input int d, input int e, input int c);
    q[0].push_back('{b, d, e, c, cyc + 3});
    q[1].push_back('{b, d, e, c, cyc + 4});
    q[2].push_back('{b, d, 0, 0, cyc + 3});
  endtask

  task automatic step(input int b, input int d, input int e, input int c);
    @(negedge rdclk);
    wrptr = g(b);
    push(b, d, e, c);
    cur = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge rdclk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".n2_gray"}, int'(if2.rdq_wrptr_gray), 0);
    chk({tag, ".n2_bin"}, int'(if2.rdq_wrptr_bin), 0);
    chk({tag, ".n2_upd"}, int'(if2.wrptr_upd), 0);
    chk({tag, ".n2_err"}, int'(if2.gray_err), 0);
    chk({tag, ".n2_cnt"}, int'(if2.err_cnt), 0);
    chk({tag, ".n3_gray"}, int'(if3.rdq_wrptr_gray), 0);
    chk({tag, ".n3_bin"}, int'(if3.rdq_wrptr_bin), 0);
    chk({tag, ".nochk_bin"}, int'(if0.rdq_wrptr_bin), 0);
  endtask

  initial begin
    // Reset held for 3 edges with a live pointer on the input.
    wrptr = g(37);
    repeat (3) @(posedge rdclk);
    @(negedge rdclk);
    chk_zero("reset1");
    // Release: the first update compares against 0.
    reset_n = 1'b1;
    push(37, 37, 0, 0);
    cur = 37;
    idle(8);

    // Reset again mid-operation, then single increment 5 -> 6.
    reset_n = 1'b0;
    wrptr = g(5);
    idle(2);
    chk_zero("reset2");
    reset_n = 1'b1;
    push(5, 5, 0, 0);
    idle(8);
    step(6, 1, 0, 0);
    idle(2);
    chk("gray_lat.n2_new", int'(if2.rdq_wrptr_gray), int'(g(6)));
    chk("gray_lat.n3_old", int'(if3.rdq_wrptr_gray), int'(g(5)));
    idle(1);
    chk("gray_lat.n3_new", int'(if3.rdq_wrptr_gray), int'(g(6)));
    idle(6);

    // Walk up to bin 511 (gray 9'h100) and wrap to 0.
    step(200, 194, 0, 0);
    step(400, 200, 0, 0);
    step(511, 111, 0, 0);
    idle(6);
    chk("wrap.gray_in", int'(if2.rdq_wrptr_gray), 9'h100);
    step(0, 1, 0, 0);
    idle(6);
    chk("wrap.no_err", int'(if2.gray_err), 0);

    // Burst jumps: exactly DEPTH is legal, DEPTH+34 is an error.
    step(10, 10, 0, 0);
    idle(5);
    step(266, 256, 0, 0);
    idle(5);
    step(10, 256, 0, 0);
    idle(5);
    step(300, 290, 1, 1);
    idle(6);
    chk("burst.err_sticky", int'(if2.gray_err), 1);
    chk("burst.cnt", int'(if3.err_cnt), 1);

    // Clear with no event.
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("clr1.err", int'(if2.gray_err), 0);
    chk("clr1.cnt", int'(if2.err_cnt), 0);
    idle(4);

    // 300 back-to-back error events; counter saturates at 255.
    for (int k = 1; k <= 300; k++) begin
      step((cur + 300) % 512, 300, 1, (k > 255) ? 255 : k);
    end
    idle(6);
    chk("sat.n2_cnt", int'(if2.err_cnt), 255);
    chk("sat.n3_cnt", int'(if3.err_cnt), 255);
    chk("sat.nochk_cnt", int'(if0.err_cnt), 0);
    chk("sat.nochk_err", int'(if0.gray_err), 0);

    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("clr2.err", int'(if2.gray_err), 0);
    chk("clr2.cnt", int'(if3.err_cnt), 0);
    idle(4);

    // Two events, then a third coinciding with err_clr at the N=2 decode edge.
    step((cur + 300) % 512, 300, 1, 1);
    idle(6);
    step((cur + 300) % 512, 300, 1, 2);
    idle(6);
    step((cur + 300) % 512, 300, 1, 1);
    idle(2);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(8);

    chk("end.n2_queue_left", q[0].size(), 0);
    chk("end.n3_queue_left", q[1].size(), 0);
    chk("end.nochk_queue_left", q[2].size(), 0);
    chk("end.n2_err", int'(if2.gray_err), 1);
    chk("end.nochk_cnt", int'(if0.err_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
